// File: rtl/seq_detector_n_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seqdet_pkg;

  typedef enum logic {MODE_OVERLAP, MODE_NONOVERLAP} seqdet_mode_t;

  localparam int unsigned MAX_LEN = 16;

  // Width needed to count 0..len inclusive.
  function automatic int unsigned fill_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_n_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_n.sv
// Parametrised serial pattern detector with registered match pulse,
// overlap/non-overlap mode and a saturating match counter.
module seq_detector_n
  import seqdet_pkg::*;
#(
  parameter int unsigned          LEN     = 4,
  parameter logic [MAX_LEN-1:0]   PATTERN = 4'b1011,
  parameter seqdet_mode_t         MODE    = MODE_OVERLAP,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic             din,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int unsigned       FILL_W    = fill_width(LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [LEN-1:0]    TARGET    = PATTERN[LEN-1:0];

  if ((LEN < 2) || (LEN > MAX_LEN)) begin : g_bad_len
    $error("seq_detector_n: LEN must be in 2..%0d", MAX_LEN);
  end
  if ((PATTERN >> LEN) != '0) begin : g_bad_pattern
    $error("seq_detector_n: PATTERN does not fit in LEN bits");
  end

  logic [LEN-1:0]    hist, hist_n, hist_d;
  logic [FILL_W-1:0] fill, fill_n, fill_d;
  logic              match;

  // match is gated by en first so an undriven din during stalls cannot reach z.
  always_comb begin
    hist_n = {hist[LEN-2:0], din};
    fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
    match  = en && (fill_n == FILL_FULL) && (hist_n == TARGET);
    hist_d = hist;
    fill_d = fill;
    if (en) begin
      hist_d = hist_n;
      fill_d = (match && (MODE == MODE_NONOVERLAP)) ? '0 : fill_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
      armed <= 1'b0;
    end else begin
      hist  <= hist_d;
      fill  <= fill_d;
      z     <= match;
      armed <= (fill_d == FILL_FULL);
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (match),
    .q       (match_count)
  );

endmodule

// File: tb/tb_seq_detector_n.sv
// Self-checking bench for seq_detector_n: three configurations share one stimulus stream.
module tb_seq_detector_n;
  import seqdet_pkg::*;

  logic clk = 1'b0;
  logic reset_n, en, clear, din;
  always #5 clk = ~clk;

  logic       z0, z1, z2, a0, a1, a2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  seq_detector_n #(.LEN(4), .PATTERN(16'b1011), .MODE(MODE_OVERLAP), .CNT_W(8)) u_ov (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .din(din),
    .z(z0), .match_count(c0), .armed(a0));
  seq_detector_n #(.LEN(4), .PATTERN(16'b1011), .MODE(MODE_NONOVERLAP), .CNT_W(8)) u_no (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .din(din),
    .z(z1), .match_count(c1), .armed(a1));
  seq_detector_n #(.LEN(2), .PATTERN(16'b11), .MODE(MODE_OVERLAP), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .din(din),
    .z(z2), .match_count(c2), .armed(a2));

  int errors = 0;
  int checks = 0;

  // Reference model: window value as an integer of the last len samples,
  // plus the number of samples seen since the window was last restarted.
  int m_len [3] = '{4, 4, 2};
  int m_pat [3] = '{11, 11, 3};
  bit m_nov [3] = '{1'b0, 1'b1, 1'b0};
  int m_cmax[3] = '{255, 255, 3};
  int m_win [3];
  int m_since[3];
  int m_cnt [3];
  bit m_z   [3];

  typedef struct {
    bit r, c, e, d;
    bit z0; int c0; bit a0;
    bit z1; int c1; bit a1;
  } vec_t;
  vec_t tbl[$];

  int sat_ez[6] = '{0, 1, 1, 1, 1, 1};
  int sat_ec[6] = '{0, 1, 2, 3, 3, 3};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit e, input bit d);
    for (int i = 0; i < 3; i++) begin
      if (!r || c) begin
        m_win[i] = 0; m_since[i] = 0; m_cnt[i] = 0; m_z[i] = 1'b0;
      end else if (e) begin
        m_win[i]   = (m_win[i] * 2 + int'(d)) % (1 << m_len[i]);
        m_since[i] = (m_since[i] + 1 > m_len[i]) ? m_len[i] : m_since[i] + 1;
        m_z[i]     = (m_since[i] == m_len[i]) && (m_win[i] == m_pat[i]);
        if (m_z[i]) begin
          if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
          if (m_nov[i]) m_since[i] = 0;
        end
      end else begin
        m_z[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit d);
    reset_n = r; clear = c; en = e;
    din = e ? d : 1'bx;
    @(posedge clk); #1;
    model_update(r, c, e, d);
    check("model_z_ov",   int'(z0), int'(m_z[0]));
    check("model_cnt_ov", int'(c0), m_cnt[0]);
    check("model_arm_ov", int'(a0), int'(m_since[0] == m_len[0]));
    check("model_z_no",   int'(z1), int'(m_z[1]));
    check("model_cnt_no", int'(c1), m_cnt[1]);
    check("model_arm_no", int'(a1), int'(m_since[1] == m_len[1]));
    check("model_z_sat",  int'(z2), int'(m_z[2]));
    check("model_cnt_sat",int'(c2), m_cnt[2]);
    check("model_arm_sat",int'(a2), int'(m_since[2] == m_len[2]));
  endtask

  task automatic add(input bit r, c, e, d, input bit ez0, input int ec0, input bit ea0,
                     input bit ez1, input int ec1, input bit ea1);
    vec_t v;
    v.r = r; v.c = c; v.e = e; v.d = d;
    v.z0 = ez0; v.c0 = ec0; v.a0 = ea0;
    v.z1 = ez1; v.c1 = ec1; v.a1 = ea1;
    tbl.push_back(v);
  endtask

  task automatic add0(input bit r, c, e, d);
    add(r, c, e, d, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; en = 1'b0; din = 1'b0;

    // Reset with toggling din, then a partial pattern.
    add0(0, 0, 1, 1); add0(0, 0, 1, 0);
    add0(1, 0, 1, 1); add0(1, 0, 1, 0); add0(1, 0, 1, 1);
    // Overlap vs non-overlap on 1,0,1,1,0,1,1 then 0.
    add0(0, 0, 0, 0);
    add0(1, 0, 1, 1); add0(1, 0, 1, 0); add0(1, 0, 1, 1);
    add(1, 0, 1, 1, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1, 1, 0, 1, 0);
    add(1, 0, 1, 1, 1, 2, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 2, 1, 0, 1, 1);
    // Stall with undriven din in the middle of a pattern.
    add0(0, 0, 0, 0);
    add0(1, 0, 1, 1); add0(1, 0, 1, 0); add0(1, 0, 1, 1);
    add0(1, 0, 0, 0); add0(1, 0, 0, 0); add0(1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 1, 1, 0);
    // Clear discards the sample on its edge; reset beats clear.
    add0(0, 0, 0, 0);
    add0(1, 0, 1, 1); add0(1, 0, 1, 0); add0(1, 0, 1, 1);
    add0(1, 1, 1, 1);
    add0(1, 0, 1, 1); add0(1, 0, 1, 0); add0(1, 0, 1, 1);
    add(1, 0, 1, 1, 1, 1, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    add0(0, 0, 1, 1);
    add0(0, 1, 1, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].d);
      check($sformatf("tbl%0d_z_ov", i),    int'(z0), int'(tbl[i].z0));
      check($sformatf("tbl%0d_cnt_ov", i),  int'(c0), tbl[i].c0);
      check($sformatf("tbl%0d_arm_ov", i),  int'(a0), int'(tbl[i].a0));
      check($sformatf("tbl%0d_z_no", i),    int'(z1), int'(tbl[i].z1));
      check($sformatf("tbl%0d_cnt_no", i),  int'(c1), tbl[i].c1);
      check($sformatf("tbl%0d_arm_no", i),  int'(a1), int'(tbl[i].a1));
    end

    // Saturation on the LEN=2, CNT_W=2 instance.
    step(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 1, 1);
      check($sformatf("sat%0d_z", k),   int'(z2), sat_ez[k]);
      check($sformatf("sat%0d_cnt", k), int'(c2), sat_ec[k]);
    end

    // Randomised traffic against the model.
    step(0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(63) != 0, $urandom_range(47) == 0,
           $urandom_range(3) != 0, $urandom_range(2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
